// File: rtl/serial_line_echo.sv
// Line-oriented serial echo: buffers received bytes up to a terminator or DEPTH,
// then retransmits the line followed by a CR/LF trailer through the tx handshake.
module serial_line_echo #(
  parameter int         DEPTH    = 40,
  parameter logic [7:0] TERM     = 8'h0A,
  parameter bit         STRIP_CR = 1'b1,
  parameter int         LEN_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       rx_data,
  input  logic             new_rx_data,
  output logic [7:0]       tx_data,
  output logic             new_tx_data,
  input  logic             tx_busy,
  output logic             line_busy,
  output logic [LEN_W-1:0] line_len,
  output logic             overflow,
  output logic             rx_drop
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [7:0]       CR      = 8'h0D;
  localparam logic [7:0]       LF      = 8'h0A;

  typedef enum logic [1:0] {RECV, SEND, TAIL_CR, TAIL_LF} state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [LEN_W-1:0] wr_cnt;
  logic [LEN_W-1:0] rd_ptr;
  logic [LEN_W-1:0] wr_next;
  logic [LEN_W-1:0] rd_next;
  logic             can_emit;
  logic             store;

  // A strobe may only follow an idle cycle, which caps the rate at one byte per two clocks.
  assign can_emit = !tx_busy && !new_tx_data;
  assign wr_next  = wr_cnt + LEN_W'(1);
  assign rd_next  = rd_ptr + LEN_W'(1);
  // The terminator check wins over CR stripping when TERM is itself 8'h0D.
  assign store    = (state == RECV) && new_rx_data && (rx_data != TERM) &&
                    !(STRIP_CR && (rx_data == CR));

  // NOTE: the line buffer has no reset; a location is always written before it is read back.
  always_ff @(posedge clk) begin
    if (store) mem[wr_cnt[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RECV;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      tx_data     <= '0;
      new_tx_data <= 1'b0;
      line_busy   <= 1'b0;
      line_len    <= '0;
      overflow    <= 1'b0;
      rx_drop     <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low every cycle so each event yields exactly one clock high.
      new_tx_data <= 1'b0;
      overflow    <= 1'b0;
      rx_drop     <= 1'b0;
      unique case (state)
        RECV: begin
          if (new_rx_data && (rx_data == TERM)) begin
            line_len  <= wr_cnt;
            rd_ptr    <= '0;
            line_busy <= 1'b1;
            state     <= (wr_cnt == '0) ? TAIL_CR : SEND;
          end else if (store) begin
            wr_cnt <= wr_next;
            if (wr_next == DEPTH_L) begin
              line_len  <= DEPTH_L;
              overflow  <= 1'b1;
              rd_ptr    <= '0;
              line_busy <= 1'b1;
              state     <= SEND;
            end
          end
        end
        SEND: begin
          rx_drop <= new_rx_data;
          if (can_emit) begin
            tx_data     <= mem[rd_ptr[AW-1:0]];
            new_tx_data <= 1'b1;
            rd_ptr      <= rd_next;
            if (rd_next == wr_cnt) state <= TAIL_CR;
          end
        end
        TAIL_CR: begin
          rx_drop <= new_rx_data;
          if (can_emit) begin
            tx_data     <= CR;
            new_tx_data <= 1'b1;
            state       <= TAIL_LF;
          end
        end
        TAIL_LF: begin
          rx_drop <= new_rx_data;
          if (can_emit) begin
            tx_data     <= LF;
            new_tx_data <= 1'b1;
            wr_cnt      <= '0;
            rd_ptr      <= '0;
            line_busy   <= 1'b0;
            state       <= RECV;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_line_echo.sv
// Bench for serial_line_echo: three configurations, a vector table, hand-written
// stall/reset sequences and randomized lines against a queue-based line model.
module tb_serial_line_echo;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DEPTH 40 strip on; 1: DEPTH 40 strip off; 2: DEPTH 4 strip on.
  logic [2:0][7:0] rx_data = '0;
  logic [2:0]      new_rx  = '0;
  logic [2:0][7:0] tx_data;
  logic [2:0]      new_tx;
  logic [2:0]      tx_busy = '0;
  logic [2:0]      hold    = '0;
  logic [2:0]      line_busy;
  logic [2:0]      overflow;
  logic [2:0]      rx_drop;
  logic [5:0]      len0;
  logic [5:0]      len1;
  logic [2:0]      len2;

  serial_line_echo #(.DEPTH(40), .TERM(8'h0A), .STRIP_CR(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[0]), .new_rx_data(new_rx[0]),
    .tx_data(tx_data[0]), .new_tx_data(new_tx[0]), .tx_busy(tx_busy[0]),
    .line_busy(line_busy[0]), .line_len(len0), .overflow(overflow[0]), .rx_drop(rx_drop[0]));

  serial_line_echo #(.DEPTH(40), .TERM(8'h0A), .STRIP_CR(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[1]), .new_rx_data(new_rx[1]),
    .tx_data(tx_data[1]), .new_tx_data(new_tx[1]), .tx_busy(tx_busy[1]),
    .line_busy(line_busy[1]), .line_len(len1), .overflow(overflow[1]), .rx_drop(rx_drop[1]));

  serial_line_echo #(.DEPTH(4), .TERM(8'h0A), .STRIP_CR(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data[2]), .new_rx_data(new_rx[2]),
    .tx_data(tx_data[2]), .new_tx_data(new_tx[2]), .tx_busy(tx_busy[2]),
    .line_busy(line_busy[2]), .line_len(len2), .overflow(overflow[2]), .rx_drop(rx_drop[2]));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Transmitter model and observers: only one instance is active at a time.
  logic [7:0] txq [$];
  int         ovf_cnt  = 0;
  int         drop_cnt = 0;
  int         rule_err = 0;
  int         busy_max = 0;
  int         busy_cnt [3];
  logic [2:0] busy_at_edge = '0;
  logic [2:0] prev_tx = '0;

  always @(posedge clk) busy_at_edge <= tx_busy;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (new_tx[i]) begin
        txq.push_back(tx_data[i]);
        if (prev_tx[i] || busy_at_edge[i]) rule_err++;
        busy_cnt[i] = int'($urandom_range(busy_max, 0));
      end else if (busy_cnt[i] > 0) begin
        busy_cnt[i]--;
      end
      prev_tx[i] = new_tx[i];
      if (overflow[i]) ovf_cnt++;
      if (rx_drop[i]) drop_cnt++;
      tx_busy[i] = hold[i] || (busy_cnt[i] > 0);
    end
  end

  function automatic int get_len(input int i);
    case (i)
      0:       return int'(len0);
      1:       return int'(len1);
      default: return int'(len2);
    endcase
  endfunction

  // Reference model: whole lines as queues, closed by LF or by reaching depth.
  logic [7:0] stim_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] line_q [$];
  int         m_len;
  int         m_ovf;

  task automatic emit_line();
    foreach (line_q[j]) exp_q.push_back(line_q[j]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    m_len = line_q.size();
    line_q.delete();
  endtask

  task automatic model(input int depth, input bit strip);
    exp_q.delete();
    line_q.delete();
    m_ovf = 0;
    foreach (stim_q[k]) begin
      if (stim_q[k] == 8'h0A) emit_line();
      else if (!(strip && stim_q[k] == 8'h0D)) begin
        line_q.push_back(stim_q[k]);
        if (line_q.size() == depth) begin
          m_ovf++;
          emit_line();
        end
      end
    end
  endtask

  task automatic send_bytes(input int i, input bit b2b, input bit gaps);
    int guard;
    @(negedge clk);
    foreach (stim_q[k]) begin
      if (!b2b) begin
        if (gaps) repeat ($urandom_range(2, 0)) @(negedge clk);
        guard = 0;
        while (line_busy[i] && guard < 2000) begin
          @(negedge clk);
          guard++;
        end
        if (guard >= 2000) check("ready_timeout", int'(line_busy[i]), 0);
      end
      rx_data[i] = stim_q[k];
      new_rx[i]  = 1'b1;
      @(negedge clk);
      new_rx[i]  = 1'b0;
    end
  endtask

  task automatic wait_tx(input int n);
    int guard = 0;
    while (txq.size() < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_count"}, txq.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      if (k < txq.size()) check($sformatf("%s_byte%0d", tag, k), int'(txq[k]), int'(exp_q[k]));
  endtask

  task automatic load_stim(input string s);
    stim_q.delete();
    for (int k = 0; k < s.len(); k++) stim_q.push_back(s[k]);
  endtask

  typedef struct {
    int          inst;
    bit          b2b;
    int          rx_n;
    logic [63:0] rx;
    int          tx_n;
    logic [63:0] tx;
    int          len;
    int          ovf;
    int          drops;
  } vec_t;

  vec_t vt [7];

  task automatic run_vec(input int n, input vec_t v);
    int o0, d0, r0;
    string tag;
    tag = $sformatf("vec%0d", n);
    stim_q.delete();
    exp_q.delete();
    for (int k = 0; k < v.rx_n; k++) stim_q.push_back(v.rx[8*(v.rx_n-1-k) +: 8]);
    for (int k = 0; k < v.tx_n; k++) exp_q.push_back(v.tx[8*(v.tx_n-1-k) +: 8]);
    txq.delete();
    o0 = ovf_cnt;
    d0 = drop_cnt;
    r0 = rule_err;
    send_bytes(v.inst, v.b2b, 1'b0);
    wait_tx(exp_q.size());
    repeat (6) @(negedge clk);
    compare_q(tag);
    check({tag, "_line_len"}, get_len(v.inst), v.len);
    check({tag, "_overflow"}, ovf_cnt - o0, v.ovf);
    check({tag, "_rx_drop"}, drop_cnt - d0, v.drops);
    check({tag, "_strobe_rule"}, rule_err - r0, 0);
    check({tag, "_line_busy"}, int'(line_busy[v.inst]), 0);
  endtask

  initial begin
    int guard, n0, o0, r0, depth;
    vt[0] = '{inst:0, b2b:1'b0, rx_n:4, rx:64'h41_42_43_0A,       tx_n:5, tx:64'h41_42_43_0D_0A,
              len:3, ovf:0, drops:0};
    vt[1] = '{inst:0, b2b:1'b0, rx_n:4, rx:64'h41_42_0D_0A,       tx_n:4, tx:64'h41_42_0D_0A,
              len:2, ovf:0, drops:0};
    vt[2] = '{inst:1, b2b:1'b0, rx_n:4, rx:64'h41_42_0D_0A,       tx_n:5, tx:64'h41_42_0D_0D_0A,
              len:3, ovf:0, drops:0};
    vt[3] = '{inst:2, b2b:1'b1, rx_n:6, rx:64'h31_32_33_34_35_36, tx_n:6, tx:64'h31_32_33_34_0D_0A,
              len:4, ovf:1, drops:2};
    vt[4] = '{inst:0, b2b:1'b0, rx_n:1, rx:64'h0A,                tx_n:2, tx:64'h0D_0A,
              len:0, ovf:0, drops:0};
    vt[5] = '{inst:2, b2b:1'b0, rx_n:5, rx:64'h61_62_63_64_0A,    tx_n:8, tx:64'h61_62_63_64_0D_0A_0D_0A,
              len:0, ovf:1, drops:0};
    vt[6] = '{inst:2, b2b:1'b0, rx_n:6, rx:64'h41_0D_42_0D_43_0A, tx_n:5, tx:64'h41_42_43_0D_0A,
              len:3, ovf:0, drops:0};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_tx_data", int'(tx_data[0]), 0);
    check("rst_new_tx", int'(new_tx[0]), 0);
    check("rst_line_busy", int'(line_busy[0]), 0);
    check("rst_line_len", get_len(0), 0);
    check("rst_overflow", int'(overflow[0]), 0);
    check("rst_rx_drop", int'(rx_drop[0]), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 7; n++) run_vec(n, vt[n]);

    // Transmitter stalled for 100 cycles after the first strobe.
    load_stim("XY\n");
    exp_q = '{8'h58, 8'h59, 8'h0D, 8'h0A};
    txq.delete();
    r0 = rule_err;
    send_bytes(0, 1'b0, 1'b0);
    guard = 0;
    while (!new_tx[0] && guard < 50) begin
      @(posedge clk);
      #1;
      guard++;
    end
    hold[0] = 1'b1;
    repeat (100) @(negedge clk);
    check("stall_strobes", txq.size(), 1);
    check("stall_line_busy", int'(line_busy[0]), 1);
    @(posedge clk);
    #1 hold[0] = 1'b0;
    wait_tx(4);
    repeat (6) @(negedge clk);
    compare_q("stall");
    check("stall_line_len", get_len(0), 2);
    check("stall_strobe_rule", rule_err - r0, 0);

    // One-cycle reset in the middle of sending HELLO.
    load_stim("HELLO\n");
    txq.delete();
    send_bytes(0, 1'b0, 1'b0);
    wait_tx(2);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_tx_data", int'(tx_data[0]), 0);
    check("midrst_new_tx", int'(new_tx[0]), 0);
    check("midrst_line_busy", int'(line_busy[0]), 0);
    check("midrst_line_len", get_len(0), 0);
    check("midrst_overflow", int'(overflow[0]), 0);
    check("midrst_rx_drop", int'(rx_drop[0]), 0);
    rst_n = 1'b1;
    n0 = txq.size();
    repeat (30) @(negedge clk);
    check("post_reset_strobes", txq.size(), n0);
    load_stim("Z\n");
    exp_q = '{8'h5A, 8'h0D, 8'h0A};
    txq.delete();
    send_bytes(0, 1'b0, 1'b0);
    wait_tx(3);
    repeat (6) @(negedge clk);
    compare_q("after_reset");
    check("after_reset_line_len", get_len(0), 1);

    // Randomized lines with a randomly busy transmitter.
    busy_max = 3;
    for (int inst = 0; inst < 3; inst += 2) begin
      depth = (inst == 2) ? 4 : 40;
      stim_q.delete();
      for (int l = 0; l < 6; l++) begin
        int ll;
        ll = int'($urandom_range(depth + 2, 0));
        for (int k = 0; k < ll; k++)
          if ($urandom_range(9, 0) == 0) stim_q.push_back(8'h0D);
          else stim_q.push_back(8'($urandom_range(8'h7E, 8'h20)));
        stim_q.push_back(8'h0A);
      end
      model(depth, 1'b1);
      txq.delete();
      o0 = ovf_cnt;
      r0 = rule_err;
      n0 = drop_cnt;
      send_bytes(inst, 1'b0, 1'b1);
      wait_tx(exp_q.size());
      repeat (10) @(negedge clk);
      compare_q($sformatf("rand%0d", inst));
      check($sformatf("rand%0d_line_len", inst), get_len(inst), m_len);
      check($sformatf("rand%0d_overflow", inst), ovf_cnt - o0, m_ovf);
      check($sformatf("rand%0d_rx_drop", inst), drop_cnt - n0, 0);
      check($sformatf("rand%0d_strobe_rule", inst), rule_err - r0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
